// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
//   Reprograms the dot4x/col4x MMCM over DRP to switch video standard at run time.
//   Holds the MMCM in reset, read-modify-writes each table entry of the selected
//   standard, releases reset and waits for lock. Runs entirely on the 50 MHz DCLK.
//   Optional build macro DRP_VERIFY_EN adds a readback check after every write.
module mmcm_drp_sequencer #(
  parameter int NUM_REGS     = 8,
  parameter int IDX_W        = 3,
  parameter int SEL_W        = 1,
  parameter int RST_HOLD     = 16,
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                   clk_in50mhz,
  input  logic                   reset_n,
  input  logic                   cfg_req,
  input  logic [SEL_W-1:0]       cfg_sel,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [SEL_W+IDX_W-1:0] tbl_addr,
  input  logic [38:0]            tbl_data,
  output logic [6:0]             drp_daddr,
  output logic                   drp_den,
  output logic                   drp_dwe,
  output logic [15:0]            drp_di,
  input  logic [15:0]            drp_do,
  input  logic                   drp_drdy,
  output logic                   mmcm_rst,
  input  logic                   mmcm_locked,
  output logic                   locked
);

  // One shared cycle counter covers every timed wait; it restarts on each state change.
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + RST_HOLD + DRDY_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    PWRUP, IDLE, ASSERT_RST, FETCH, READ, WAIT_RD, WRITE, WAIT_WR, HOLD, WAIT_LOCK
`ifdef DRP_VERIFY_EN
    , VERIFY, WAIT_VF
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel_q;
  logic [6:0]       daddr_q;
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic [15:0]      di_q;
  logic             err_q;
  logic             done_q;
  logic             lock_meta;
  logic             lock_sync;

  logic accept, set_err, ld_entry, ld_di, idx_inc;

  // Mask bit 1 keeps the bit currently in the MMCM, mask bit 0 takes the table value.
  function automatic logic [15:0] rmw_merge(input logic [15:0] cur,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (cur & mask) | (data & ~mask);
  endfunction

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    set_err   = 1'b0;
    ld_entry  = 1'b0;
    ld_di     = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      PWRUP:      if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
      IDLE: begin
        if (cfg_req) begin
          accept    = 1'b1;
          state_nxt = ASSERT_RST;
        end
      end
      ASSERT_RST: state_nxt = FETCH;
      // First FETCH cycle presents the address, second captures the ROM word.
      FETCH: begin
        if (cnt != '0) begin
          ld_entry  = 1'b1;
          state_nxt = READ;
        end
      end
      READ:       state_nxt = WAIT_RD;
      WAIT_RD: begin
        if (drp_drdy) begin
          ld_di     = 1'b1;
          state_nxt = WRITE;
        end else if (cnt == DRDY_LAST) begin
          set_err   = 1'b1;
          state_nxt = HOLD;
        end
      end
      WRITE:      state_nxt = WAIT_WR;
      WAIT_WR: begin
        if (drp_drdy) begin
`ifdef DRP_VERIFY_EN
          state_nxt = VERIFY;
`else
          if (idx == IDX_LAST) begin
            state_nxt = HOLD;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = FETCH;
          end
`endif
        end else if (cnt == DRDY_LAST) begin
          set_err   = 1'b1;
          state_nxt = HOLD;
        end
      end
`ifdef DRP_VERIFY_EN
      VERIFY:     state_nxt = WAIT_VF;
      WAIT_VF: begin
        if (drp_drdy) begin
          if ((drp_do ^ di_q) != 16'h0000) begin
            set_err   = 1'b1;
            state_nxt = HOLD;
          end else if (idx == IDX_LAST) begin
            state_nxt = HOLD;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = FETCH;
          end
        end else if (cnt == DRDY_LAST) begin
          set_err   = 1'b1;
          state_nxt = HOLD;
        end
      end
`endif
      HOLD:       if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_nxt = IDLE;
        end else if (cnt == LOCK_LAST) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:    state_nxt = PWRUP;
    endcase
  end

  // Control state: FSM, wait counter, index, flags and lock synchroniser.
  always_ff @(posedge clk_in50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PWRUP;
      cnt       <= '0;
      idx       <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
      done_q    <= (state != IDLE) && (state_nxt == IDLE);
      lock_meta <= mmcm_locked;
      lock_sync <= lock_meta;
      if (accept) begin
        sel_q <= cfg_sel;
        idx   <= '0;
        err_q <= 1'b0;
      end else begin
        if (idx_inc) idx   <= idx + 1'b1;
        if (set_err) err_q <= 1'b1;
      end
    end
  end

  // DRP address and write data seen by the MMCM; cleared by reset so the port idles at zero.
  always_ff @(posedge clk_in50mhz or negedge reset_n) begin
    if (!reset_n) begin
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      if (ld_entry) daddr_q <= tbl_data[38:32];
      if (ld_di)    di_q    <= rmw_merge(drp_do, mask_q, data_q);
    end
  end

  // Table mask/data are consumed only after a fresh load, so they carry no reset.
  always_ff @(posedge clk_in50mhz) begin
    if (ld_entry) begin
      mask_q <= tbl_data[31:16];
      data_q <= tbl_data[15:0];
    end
  end

  // DRP strobes are pure state decodes, so only one access is ever in flight.
  always_comb begin
    drp_den = (state == READ) || (state == WRITE);
`ifdef DRP_VERIFY_EN
    if (state == VERIFY) drp_den = 1'b1;
`endif
    drp_dwe = (state == WRITE);
  end

  assign tbl_addr  = {sel_q, idx};
  assign drp_daddr = daddr_q;
  assign drp_di    = di_q;
  assign cfg_busy  = (state != IDLE);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign mmcm_rst  = (state != IDLE) && (state != WAIT_LOCK);
  assign locked    = lock_sync && (state == IDLE);

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Directed bench for mmcm_drp_sequencer with a behavioural DRP/MMCM model and table ROM.
module tb_mmcm_drp_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [0:0]  cfg_sel = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [3:0]  tbl_addr;
  logic [38:0] tbl_data;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        locked;

  int checks = 0;
  int errors = 0;

  mmcm_drp_sequencer dut (
    .clk_in50mhz(clk), .reset_n(reset_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked), .locked(locked)
  );

  initial forever #5 clk = ~clk;

  // ---------------- table ROM and DRP/MMCM model ----------------
  function automatic logic [38:0] rom(input logic sel, input logic [2:0] i);
    logic [6:0]  a;
    logic [15:0] m;
    logic [15:0] d;
    a = 7'h08 + {4'd0, i};
    m = i[0] ? 16'h00FF : 16'hF000;
    d = sel ? (16'h0145 + {13'd0, i} * 16'h1111) : (16'h0800 + {13'd0, i});
    return {a, m, d};
  endfunction

  function automatic logic [15:0] init_val(input int a);
    return 16'hA3C0 + 16'(a - 8) * 16'h0101;
  endfunction

  function automatic logic [15:0] exp_wr(input logic sel, input logic [2:0] i);
    logic [38:0] e;
    e = rom(sel, i);
    return (init_val(int'(e[38:32])) & e[31:16]) | (e[15:0] & ~e[31:16]);
  endfunction

  logic [15:0] mem [0:127];
  logic [6:0]  wlog_a [0:15];
  logic [15:0] wlog_d [0:15];
  int          wcnt = 0;
  int          viol = 0;
  logic        p1 = 1'b0;
  logic        mem_init = 1'b0;
  logic        stall_en = 1'b0;
  logic [6:0]  stall_addr = 7'h00;
  logic        corrupt_en = 1'b0;
  logic [6:0]  corrupt_addr = 7'h00;
  logic        force_unlock = 1'b0;
  logic [7:0]  lock_cnt = 8'd0;
  logic        lock_r = 1'b0;

  always @(posedge clk) tbl_data <= rom(tbl_addr[3], tbl_addr[2:0]);

  always @(posedge clk) begin
    p1       <= 1'b0;
    drp_drdy <= p1;
    if (mem_init) begin
      for (int a = 0; a < 128; a++) mem[a] <= init_val(a);
      wcnt <= 0;
    end
    if (drp_den) begin
      if (p1 || drp_drdy) viol <= viol + 1;
      if (drp_dwe) begin
        mem[drp_daddr] <= drp_di;
        if (wcnt < 16) begin
          wlog_a[wcnt] <= drp_daddr;
          wlog_d[wcnt] <= drp_di;
        end
        wcnt <= wcnt + 1;
        p1   <= 1'b1;
      end else begin
        drp_do <= mem[drp_daddr] ^ ((corrupt_en && drp_daddr == corrupt_addr) ? 16'h0001 : 16'h0000);
        p1     <= !(stall_en && drp_daddr == stall_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (mmcm_rst) begin
      lock_cnt <= 8'd0;
      lock_r   <= 1'b0;
    end else if (lock_cnt != 8'd100) begin
      lock_cnt <= lock_cnt + 8'd1;
    end else begin
      lock_r <= 1'b1;
    end
  end
  assign mmcm_locked = lock_r && !force_unlock;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [0:0] sel);
    @(negedge clk);
    cfg_sel = sel;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
  endtask

  task automatic reinit_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  // Waits for cfg_done; optionally pulses cfg_req for two cycles starting at poke_at.
  task automatic wait_done(input int budget, input int poke_at, output int ndone);
    int cyc;
    ndone = 0;
    cyc   = 0;
    while (ndone == 0 && cyc < budget) begin
      cfg_req = (poke_at >= 0) && (cyc == poke_at || cyc == poke_at + 1);
      @(negedge clk);
      cyc++;
      if (cfg_done) ndone++;
    end
    cfg_req = 1'b0;
  endtask

  task automatic count_until_rst_low(input int budget, output int n);
    n = 0;
    while (mmcm_rst && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int nd;
    int extra;
    bit seen;

    // Reset values
    #2;
    chk("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("rst_busy",     32'(cfg_busy), 32'd1);
    chk("rst_done",     32'(cfg_done), 32'd0);
    chk("rst_err",      32'(cfg_err),  32'd0);
    chk("rst_den",      32'(drp_den),  32'd0);
    chk("rst_dwe",      32'(drp_dwe),  32'd0);
    chk("rst_daddr",    32'(drp_daddr), 32'd0);
    chk("rst_di",       32'(drp_di),   32'd0);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_locked",   32'(locked),   32'd0);
    reinit_mem();

    // Power-up: RST held 16 cycles, then lock after the model's 100 cycles
    @(negedge clk);
    reset_n = 1'b1;
    count_until_rst_low(100, n);
    chk("pwrup_hold_cycles", 32'(n), 32'd16);
    wait_done(500, -1, nd);
    chk("pwrup_done", 32'(nd), 32'd1);
    chk("pwrup_locked", 32'(locked), 32'd1);
    chk("pwrup_err", 32'(cfg_err), 32'd0);
    chk("pwrup_busy", 32'(cfg_busy), 32'd0);

    // NTSC load with extra cfg_req pulses while busy
    reinit_mem();
    start_req(1'b1);
    chk("ntsc_busy", 32'(cfg_busy), 32'd1);
    chk("ntsc_mmcm_rst", 32'(mmcm_rst), 32'd1);
    wait_done(3000, 30, nd);
    chk("ntsc_done", 32'(nd), 32'd1);
    chk("ntsc_err", 32'(cfg_err), 32'd0);
    chk("ntsc_locked", 32'(locked), 32'd1);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cfg_done) extra++;
    end
    chk("ntsc_single_done", 32'(extra), 32'd0);
    chk("ntsc_write_count", 32'(wcnt), 32'd8);
    chk("ntsc_first_addr", 32'(wlog_a[0]), 32'h08);
    chk("ntsc_first_data", 32'(wlog_d[0]), 32'hA145);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ntsc_addr%0d", i), 32'(wlog_a[i]), 32'(8 + i));
      chk($sformatf("ntsc_data%0d", i), 32'(wlog_d[i]), 32'(exp_wr(1'b1, 3'(i))));
    end
    chk("ntsc_one_outstanding", 32'(viol), 32'd0);

    // DRDY never returns for the idx 3 read: 63 waiting cycles, then abort
    reinit_mem();
    stall_addr = 7'h0B;
    stall_en   = 1'b1;
    start_req(1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      seen = drp_den && !drp_dwe && (drp_daddr == 7'h0B);
    end
    chk("stall_read_seen", 32'(seen), 32'd1);
    n = 0;
    while (!cfg_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    // READ cycle, then 63 WAIT_RD cycles; the flag shows on the cycle after the last one.
    chk("stall_timeout_cycles", 32'(n), 32'd64);
    wait_done(500, -1, nd);
    chk("stall_done", 32'(nd), 32'd1);
    chk("stall_err", 32'(cfg_err), 32'd1);
    chk("stall_rst_released", 32'(mmcm_rst), 32'd0);
    chk("stall_write_count", 32'(wcnt), 32'd3);
    chk("stall_last_addr", 32'(wlog_a[2]), 32'h0A);
    stall_en = 1'b0;

    // Lock never arrives: error exactly LOCK_TIMEOUT cycles after RST release
    reinit_mem();
    force_unlock = 1'b1;
    start_req(1'b0);
    count_until_rst_low(3000, n);
    chk("lockto_rst_released", 32'(mmcm_rst), 32'd0);
    n = 0;
    while (!cfg_err && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("lockto_cycles", 32'(n), 32'd65535);
    chk("lockto_done", 32'(cfg_done), 32'd1);
    chk("lockto_locked", 32'(locked), 32'd0);
    force_unlock = 1'b0;
    start_req(1'b1);
    chk("lockto_err_cleared", 32'(cfg_err), 32'd0);
    chk("lockto_busy_again", 32'(cfg_busy), 32'd1);
    wait_done(3000, -1, nd);
    chk("lockto_recover_done", 32'(nd), 32'd1);
    chk("lockto_recover_err", 32'(cfg_err), 32'd0);

    // Reset asserted while waiting for a write acknowledge
    reinit_mem();
    start_req(1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      seen = drp_den && drp_dwe && (drp_daddr == 7'h0A);
    end
    chk("midrst_write_seen", 32'(seen), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    chk("midrst_den", 32'(drp_den), 32'd0);
    chk("midrst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("midrst_daddr", 32'(drp_daddr), 32'd0);
    chk("midrst_busy", 32'(cfg_busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_until_rst_low(100, n);
    chk("midrst_pwrup_hold", 32'(n), 32'd16);
    wait_done(500, -1, nd);
    chk("midrst_done", 32'(nd), 32'd1);
    chk("midrst_locked", 32'(locked), 32'd1);
    chk("midrst_partial_writes", 32'(mem[7'h08]), 32'(exp_wr(1'b1, 3'd0)));

`ifdef DRP_VERIFY_EN
    // Corrupted readback on idx 2 raises the error and stops further writes
    reinit_mem();
    corrupt_addr = 7'h0A;
    corrupt_en   = 1'b1;
    start_req(1'b0);
    wait_done(3000, -1, nd);
    chk("verify_done", 32'(nd), 32'd1);
    chk("verify_err", 32'(cfg_err), 32'd1);
    chk("verify_write_count", 32'(wcnt), 32'd3);
    corrupt_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
